// File: rtl/seg7_scan.sv
// Multiplexed seven-segment display driver with double-buffered loading,
// leading-zero blanking, decimal points, per-digit blinking and ghost blanking.
module seg7_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic                  lz_blank,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{SEL_ACTIVE_LOW != 0}};

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'hFC;  4'h1: glyph = 8'h60;
            4'h2: glyph = 8'hDA;  4'h3: glyph = 8'hF2;
            4'h4: glyph = 8'h66;  4'h5: glyph = 8'hB6;
            4'h6: glyph = 8'hBE;  4'h7: glyph = 8'hE0;
            4'h8: glyph = 8'hFE;  4'h9: glyph = 8'hF6;
            4'hA: glyph = 8'hEE;  4'hB: glyph = 8'h3E;
            4'hC: glyph = 8'h9C;  4'hD: glyph = 8'h7A;
            4'hE: glyph = 8'h9E;  default: glyph = 8'h8E;
        endcase
    endfunction

    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic                run_reg;
    logic [4*DIGITS-1:0] staging_reg, staging_next;
    logic [4*DIGITS-1:0] active_reg, active_next;
    logic                pending_reg, pending_next;
    logic [FW-1:0]       frame_cnt_reg, frame_cnt_next;
    logic                blink_phase_reg, blink_phase_next;
    logic [7:0]          seg_n_reg, seg_n_next;
    logic [DIGITS-1:0]   dig_sel_reg, dig_sel_next;
    logic                frame_done_reg, frame_done_next;
    logic                slot_end, frame_end;
    logic [DIGITS-1:0]   upper_zero, dark;
    logic [7:0]          pat [DIGITS];

    // cnt/idx track the cycle currently on the outputs; the first cycle
    // after reset holds position 0 instead of advancing.
    always_comb begin
        slot_end  = run_reg && (cnt_reg == CNT_LAST);
        frame_end = slot_end && (idx_reg == IDX_LAST);
        cnt_next  = (!run_reg || slot_end) ? '0 : cnt_reg + CW'(1);
        if (!run_reg || frame_end)
            idx_next = '0;
        else if (slot_end)
            idx_next = idx_reg + IW'(1);
        else
            idx_next = idx_reg;

        staging_next = staging_reg;
        pending_next = pending_reg;
        active_next  = active_reg;
        if (frame_end) begin
            if (load) begin
                active_next  = value;
                staging_next = value;
                pending_next = 1'b0;
            end else if (pending_reg) begin
                active_next  = staging_reg;
                pending_next = 1'b0;
            end
        end else if (load) begin
            staging_next = value;
            pending_next = 1'b1;
        end

        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (frame_end) begin
            if (frame_cnt_reg == FRM_LAST) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + FW'(1);
            end
        end
    end

    // Per-digit lit pattern for the position about to be displayed.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign upper_zero[gi] = (active_next[4*DIGITS-1:4*gi] == '0);
            if (gi == 0) begin : g_first
                assign dark[gi] = ~digit_en[gi] | (blink_mask[gi] & blink_phase_next);
            end else begin : g_upper
                assign dark[gi] = ~digit_en[gi] | (blink_mask[gi] & blink_phase_next)
                                | (lz_blank & upper_zero[gi]);
            end
            assign pat[gi] = dark[gi] ? 8'h00
                           : (glyph(active_next[4*gi +: 4]) | {7'b0, dp_en[gi]});
        end
    endgenerate

    always_comb begin
        seg_n_next      = (int'(cnt_next) < BLANK_CYC) ? 8'hFF : ~pat[idx_next];
        dig_sel_next    = SEL_IDLE ^ (DIGITS'(1) << idx_next);
        frame_done_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            idx_reg         <= '0;
            run_reg         <= 1'b0;
            staging_reg     <= '0;
            active_reg      <= '0;
            pending_reg     <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg_n_reg       <= 8'hFF;
            dig_sel_reg     <= SEL_IDLE;
            frame_done_reg  <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            run_reg         <= 1'b1;
            staging_reg     <= staging_next;
            active_reg      <= active_next;
            pending_reg     <= pending_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            seg_n_reg       <= seg_n_next;
            dig_sel_reg     <= dig_sel_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign seg_n      = seg_n_reg;
    assign dig_sel    = dig_sel_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: per-cycle expected outputs are queued per
// frame and compared against the DUT one cycle at a time.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_en;
    logic        lz_blank;
    logic [3:0]  blink_mask;
    logic [7:0]  seg_n;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] sb [$];

    seg7_scan #(
        .DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .digit_en(digit_en), .dp_en(dp_en), .lz_blank(lz_blank),
        .blink_mask(blink_mask), .seg_n(seg_n), .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s sel/seg/fd got=%h/%h/%b want=%h/%h/%b",
                   tag, obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
        end
    endtask

    // Queue n cycles of one frame (digit 3..0 patterns), then run and compare.
    // Loads are driven after checking cycle c1 / c2 of this frame.
    task automatic run_frame(input int f, input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0, input int n,
                             input int c1, input logic [15:0] v1,
                             input int c2, input logic [15:0] v2);
        logic [7:0]  s [4];
        logic [3:0]  sel;
        logic [12:0] e;
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < n; k++) begin
            sel = 4'hF ^ (4'h1 << (k / 8));
            sb.push_back({sel, ((k % 8) < 2) ? 8'hFF : s[k / 8], k == 31});
        end
        for (int k = 0; k < n; k++) begin
            step();
            e = sb.pop_front();
            check($sformatf("frame%0d_cyc%0d", f, k), {dig_sel, seg_n, frame_done}, e);
            load = 1'b0;
            if (k == c1) begin load = 1'b1; value = v1; end
            if (k == c2) begin load = 1'b1; value = v2; end
        end
    endtask

    initial begin
        rst = 1'b1; value = '0; load = 1'b0; digit_en = 4'hF;
        dp_en = '0; lz_blank = 1'b0; blink_mask = '0;
        step();
        check("reset", {dig_sel, seg_n, frame_done}, {4'hF, 8'hFF, 1'b0});
        rst = 1'b0;

        // Value 0 after reset, then 1A3F loaded in the frame_done cycle.
        run_frame(0, 8'h03, 8'h03, 8'h03, 8'h03, 32, 31, 16'h1A3F, -1, 16'h0);
        // Two loads mid-frame: current frame unchanged, last load wins next.
        run_frame(1, 8'h9F, 8'h11, 8'h0D, 8'h71, 32, 5, 16'h1111, 20, 16'h2222);
        run_frame(2, 8'h25, 8'h25, 8'h25, 8'h25, 32, 31, 16'h0040, -1, 16'h0);
        lz_blank = 1'b1;
        run_frame(3, 8'hFF, 8'hFF, 8'h99, 8'h03, 32, 31, 16'h0000, -1, 16'h0);
        run_frame(4, 8'hFF, 8'hFF, 8'hFF, 8'h03, 32, 31, 16'h0008, -1, 16'h0);
        lz_blank = 1'b0;
        dp_en = 4'b0010;
        run_frame(5, 8'h03, 8'h03, 8'h02, 8'h01, 32, 31, 16'h1A3F, -1, 16'h0);
        dp_en = 4'b0000;
        digit_en = 4'b1011;
        run_frame(6, 8'h9F, 8'hFF, 8'h0D, 8'h71, 32, -1, 16'h0, -1, 16'h0);
        digit_en = 4'hF;
        // Blink phase is high in frames 6-7 and 10-11 counted from reset.
        blink_mask = 4'b0001;
        run_frame(7, 8'h9F, 8'h11, 8'h0D, 8'hFF, 32, -1, 16'h0, -1, 16'h0);
        run_frame(8, 8'h9F, 8'h11, 8'h0D, 8'h71, 32, -1, 16'h0, -1, 16'h0);
        run_frame(9, 8'h9F, 8'h11, 8'h0D, 8'h71, 32, -1, 16'h0, -1, 16'h0);
        run_frame(10, 8'h9F, 8'h11, 8'h0D, 8'hFF, 32, -1, 16'h0, -1, 16'h0);
        // Pending load, then reset mid-slot of digit 2 (cycle 20).
        run_frame(11, 8'h9F, 8'h11, 8'h0D, 8'hFF, 21, 3, 16'h4444, -1, 16'h0);
        rst = 1'b1;
        step();
        check("mid_reset", {dig_sel, seg_n, frame_done}, {4'hF, 8'hFF, 1'b0});
        rst = 1'b0;
        // Active cleared, pending load dropped, blink phase restarted.
        run_frame(12, 8'h03, 8'h03, 8'h03, 8'h03, 32, -1, 16'h0, -1, 16'h0);
        run_frame(13, 8'h03, 8'h03, 8'h03, 8'h03, 32, -1, 16'h0, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
